// File: rtl/decode_stage_bypass_pkg.sv
// Shared decode types: opcodes, branch funct3 codes, instruction classes,
// exception causes and the micro-op handed to execute.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // One-hot class; CLS_NONE marks an undecodable word.
    typedef enum logic [6:0] {
        CLS_NONE   = 7'b0000000,
        CLS_ALU    = 7'b0000001,
        CLS_LOAD   = 7'b0000010,
        CLS_STORE  = 7'b0000100,
        CLS_BRANCH = 7'b0001000,
        CLS_JAL    = 7'b0010000,
        CLS_JALR   = 7'b0100000,
        CLS_SYSTEM = 7'b1000000
    } instr_class_t;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_FETCH   = 2'd1,
        EXC_ILLEGAL = 2'd2
    } exc_cause_t;

    typedef struct packed {
        instr_class_t cls;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [4:0]   rd;
        logic         rd_valid;
        logic [31:0]  imm;
    } uop_t;

    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/decode_stage_bypass_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// valid/ready: a beat moves on a rising edge where both are high; the sender holds its payload stable while valid && !ready.
interface decode_stage_bypass_if import decode_pkg::*; #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            in_fetch_fault;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    uop_t            out_uop;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic            out_exc;
    exc_cause_t      out_exc_cause;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    modport slave (
        input  in_valid, in_pc, in_instr, in_fetch_fault, out_ready,
        output in_ready, out_valid, out_pc, out_uop, out_rs1_data, out_rs2_data,
               out_exc, out_exc_cause, redirect_valid, redirect_target
    );

    modport master (
        output in_valid, in_pc, in_instr, in_fetch_fault, out_ready,
        input  in_ready, out_valid, out_pc, out_uop, out_rs1_data, out_rs2_data,
               out_exc, out_exc_cause, redirect_valid, redirect_target
    );

endinterface

// File: rtl/decode_stage_bypass_decoder.sv
// Combinational RV32I field decoder: class, immediate, register usage and legality.
module decode_stage_bypass_decoder import decode_pkg::*; (
    input  logic [31:0] instr,
    output uop_t        uop,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        writes_rd;

    assign opcode  = instr[6:0];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        uop        = '0;
        uop.cls    = CLS_NONE;
        uop.funct3 = instr[14:12];
        uop.funct7 = instr[31:25];
        uop.rd     = instr[11:7];
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        illegal    = 1'b0;
        writes_rd  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                uop.cls   = CLS_ALU;
                uop.imm   = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                uop.cls   = CLS_JAL;
                uop.imm   = imm_j;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                uop.cls   = CLS_JALR;
                uop.imm   = imm_i;
                rs1_used  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                uop.cls  = CLS_BRANCH;
                uop.imm  = imm_b;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                illegal  = !branch_f3_legal(instr[14:12]);
            end
            OPC_LOAD: begin
                uop.cls   = CLS_LOAD;
                uop.imm   = imm_i;
                rs1_used  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                uop.cls  = CLS_STORE;
                uop.imm  = imm_s;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                uop.cls   = CLS_ALU;
                uop.imm   = imm_i;
                rs1_used  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                uop.cls   = CLS_ALU;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                uop.cls = CLS_SYSTEM;
                uop.imm = imm_i;
            end
            default: illegal = 1'b1;
        endcase
        // x0 is never a real write target.
        uop.rd_valid = writes_rd && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage_bypass.sv
// Decode stage: one holding register, operand resolution through bypass/RF,
// hazard stall, exception tagging and branch/jump redirect.
module decode_stage_bypass import decode_pkg::*; #(
    parameter  int XLEN          = 32,
    parameter  int NUM_REGISTERS = 32,
    parameter  int BYPASS_PORTS  = 2,
    localparam int RW            = $clog2(NUM_REGISTERS)
) (
    input  logic                         clk,
    input  logic                         rst,
    decode_stage_bypass_if.slave         bus,
    output logic [RW-1:0]                rf_rs1_idx,
    output logic [RW-1:0]                rf_rs2_idx,
    input  logic [XLEN-1:0]              rf_rs1_data,
    input  logic [XLEN-1:0]              rf_rs2_data,
    input  logic                         rf_rs1_busy,
    input  logic                         rf_rs2_busy,
    input  logic [BYPASS_PORTS-1:0]      byp_valid,
    input  logic [BYPASS_PORTS*RW-1:0]   byp_idx,
    input  logic [BYPASS_PORTS*XLEN-1:0] byp_data,
    input  logic                         flush
);

    typedef struct packed {
        logic            hazard;
        logic [XLEN-1:0] data;
    } operand_t;

    // x0 reads zero; otherwise the lowest-numbered matching bypass wins over the RF.
    function automatic operand_t select_operand(
        input logic [RW-1:0]                idx,
        input logic [XLEN-1:0]              rf_data,
        input logic                         rf_busy,
        input logic [BYPASS_PORTS-1:0]      bv,
        input logic [BYPASS_PORTS*RW-1:0]   bi,
        input logic [BYPASS_PORTS*XLEN-1:0] bd
    );
        operand_t r;
        logic     hit;
        r.hazard = 1'b0;
        r.data   = '0;
        hit      = (idx == '0);
        for (int p = 0; p < BYPASS_PORTS; p++) begin
            if (!hit && bv[p] && (bi[p*RW +: RW] == idx)) begin
                hit    = 1'b1;
                r.data = bd[p*XLEN +: XLEN];
            end
        end
        if (!hit) begin
            if (rf_busy) r.hazard = 1'b1;
            else         r.data   = rf_data;
        end
        return r;
    endfunction

    logic            held_q, held_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            fault_q, fault_d;

    uop_t            uop;
    logic [4:0]      dec_rs1, dec_rs2;
    logic            rs1_used, rs2_used, illegal;
    operand_t        op1, op2;
    logic            hazard, exc, out_valid, transfer, in_ready, accept;
    logic            br_taken, taken;
    logic [XLEN-1:0] imm_x, jalr_sum;

    decode_stage_bypass_decoder u_decoder (
        .instr    (instr_q),
        .uop      (uop),
        .rs1_idx  (dec_rs1),
        .rs2_idx  (dec_rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .illegal  (illegal)
    );

    assign rf_rs1_idx = RW'(dec_rs1);
    assign rf_rs2_idx = RW'(dec_rs2);

    assign op1 = select_operand(rf_rs1_idx, rf_rs1_data, rf_rs1_busy, byp_valid, byp_idx, byp_data);
    assign op2 = select_operand(rf_rs2_idx, rf_rs2_data, rf_rs2_busy, byp_valid, byp_idx, byp_data);

    // Excepting instructions never wait on operands they will not use.
    assign hazard    = (rs1_used && op1.hazard) || (rs2_used && op2.hazard);
    assign exc       = fault_q || illegal;
    assign out_valid = held_q && !flush && (exc || !hazard);
    assign transfer  = out_valid && bus.out_ready;
    assign in_ready  = !flush && (!held_q || transfer);
    assign accept    = bus.in_valid && in_ready;

    assign imm_x    = XLEN'($signed(uop.imm));
    assign jalr_sum = op1.data + imm_x;

    always_comb begin
        br_taken = 1'b0;
        case (uop.funct3)
            F3_BEQ:  br_taken = (op1.data == op2.data);
            F3_BNE:  br_taken = (op1.data != op2.data);
            F3_BLT:  br_taken = ($signed(op1.data) <  $signed(op2.data));
            F3_BGE:  br_taken = ($signed(op1.data) >= $signed(op2.data));
            F3_BLTU: br_taken = (op1.data <  op2.data);
            F3_BGEU: br_taken = (op1.data >= op2.data);
            default: br_taken = 1'b0;
        endcase
    end

    assign taken = !exc && ((uop.cls == CLS_JAL) || (uop.cls == CLS_JALR) ||
                            ((uop.cls == CLS_BRANCH) && br_taken));

    // Redirect only fires on the handoff edge, so a stalled branch pulses exactly once.
    assign bus.redirect_valid  = transfer && taken;
    assign bus.redirect_target = (uop.cls == CLS_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                       : pc_q + imm_x;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_pc        = pc_q;
    assign bus.out_uop       = uop;
    assign bus.out_rs1_data  = op1.data;
    assign bus.out_rs2_data  = op2.data;
    assign bus.out_exc       = out_valid && exc;
    assign bus.out_exc_cause = fault_q ? EXC_FETCH : (illegal ? EXC_ILLEGAL : EXC_NONE);

    always_comb begin
        held_d  = held_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (flush) begin
            held_d = 1'b0;
        end else if (accept) begin
            held_d  = 1'b1;
            pc_d    = bus.in_pc;
            instr_d = bus.in_instr;
            fault_d = bus.in_fetch_fault;
        end else if (transfer) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) held_q <= 1'b0;
        else     held_q <= held_d;
        pc_q    <= pc_d;
        instr_q <= instr_d;
        fault_q <= fault_d;
    end

endmodule

// File: tb/tb_decode_stage_bypass.sv
// Bench for decode_stage_bypass: directed scenarios with literal expectations
// plus an ISA-level reference model checked every cycle.
module tb_decode_stage_bypass;
    import decode_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NBP  = 2;
    localparam int RW   = 5;

    localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_BEQ   = 32'h00208863; // beq  x1,x2,+16
    localparam logic [31:0] I_JALR  = 32'h00828067; // jalr x0,8(x5)
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_BADBR = 32'h0020A863; // branch funct3=010

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_bypass_if #(.XLEN(XLEN)) bus ();

    logic [RW-1:0]       rf_rs1_idx, rf_rs2_idx;
    logic [XLEN-1:0]     rf_rs1_data, rf_rs2_data;
    logic                busy1, busy2, flush;
    logic [NBP-1:0]      byp_valid;
    logic [NBP*RW-1:0]   byp_idx;
    logic [NBP*XLEN-1:0] byp_data;
    logic [XLEN-1:0]     regs [NREG];

    assign rf_rs1_data = regs[rf_rs1_idx];
    assign rf_rs2_data = regs[rf_rs2_idx];

    decode_stage_bypass #(.XLEN(XLEN), .NUM_REGISTERS(NREG), .BYPASS_PORTS(NBP)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_rs1_idx  (rf_rs1_idx),
        .rf_rs2_idx  (rf_rs2_idx),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rf_rs1_busy (busy1),
        .rf_rs2_busy (busy2),
        .byp_valid   (byp_valid),
        .byp_idx     (byp_idx),
        .byp_data    (byp_data),
        .flush       (flush)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int redir_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the stage should be holding.
    logic            m_held;
    logic [XLEN-1:0] m_pc;
    logic [31:0]     m_instr;
    logic            m_fault;

    logic            e_in_ready, e_out_valid, e_exc, e_exc_any, e_redirect;
    logic [XLEN-1:0] e_target, e_rs1, e_rs2;
    logic            e_use1, e_use2, e_rdv;
    logic [31:0]     e_imm;
    instr_class_t    e_cls;
    exc_cause_t      e_cause;

    function automatic logic [XLEN:0] m_operand(input logic [4:0] r, input logic busy);
        if (r == 5'd0) return '0;
        for (int p = 0; p < NBP; p++)
            if (byp_valid[p] && byp_idx[p*RW +: RW] == r) return {1'b0, byp_data[p*XLEN +: XLEN]};
        if (busy) return {1'b1, {XLEN{1'b0}}};
        return {1'b0, regs[r]};
    endfunction

    task automatic model_eval();
        logic [6:0] op;
        logic [2:0] f3;
        logic       legal, writes, taken;
        logic [XLEN:0] o1, o2;
        op = m_instr[6:0];
        f3 = m_instr[14:12];
        e_cls = CLS_NONE; e_imm = '0; e_use1 = 1'b0; e_use2 = 1'b0;
        legal = 1'b1; writes = 1'b0; taken = 1'b0;
        case (op)
            7'h37, 7'h17: begin e_cls = CLS_ALU; e_imm = {m_instr[31:12], 12'b0}; writes = 1'b1; end
            7'h6F: begin
                e_cls = CLS_JAL; writes = 1'b1; taken = 1'b1;
                e_imm = {{11{m_instr[31]}}, m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21], 1'b0};
            end
            7'h67: begin e_cls = CLS_JALR; e_imm = {{20{m_instr[31]}}, m_instr[31:20]}; e_use1 = 1'b1; writes = 1'b1; taken = 1'b1; end
            7'h63: begin
                e_cls = CLS_BRANCH; e_use1 = 1'b1; e_use2 = 1'b1;
                e_imm = {{19{m_instr[31]}}, m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0};
                legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'h03: begin e_cls = CLS_LOAD; e_imm = {{20{m_instr[31]}}, m_instr[31:20]}; e_use1 = 1'b1; writes = 1'b1; end
            7'h23: begin e_cls = CLS_STORE; e_imm = {{20{m_instr[31]}}, m_instr[31:25], m_instr[11:7]}; e_use1 = 1'b1; e_use2 = 1'b1; end
            7'h13: begin e_cls = CLS_ALU; e_imm = {{20{m_instr[31]}}, m_instr[31:20]}; e_use1 = 1'b1; writes = 1'b1; end
            7'h33: begin e_cls = CLS_ALU; e_use1 = 1'b1; e_use2 = 1'b1; writes = 1'b1; end
            7'h0F, 7'h73: begin e_cls = CLS_SYSTEM; e_imm = {{20{m_instr[31]}}, m_instr[31:20]}; end
            default: legal = 1'b0;
        endcase
        e_rdv = writes && (m_instr[11:7] != 5'd0);
        o1 = m_operand(m_instr[19:15], busy1);
        o2 = m_operand(m_instr[24:20], busy2);
        e_rs1 = o1[XLEN-1:0];
        e_rs2 = o2[XLEN-1:0];
        if (op == 7'h63) begin
            case (f3)
                3'd0: taken = (e_rs1 == e_rs2);
                3'd1: taken = (e_rs1 != e_rs2);
                3'd4: taken = ($signed(e_rs1) <  $signed(e_rs2));
                3'd5: taken = ($signed(e_rs1) >= $signed(e_rs2));
                3'd6: taken = (e_rs1 <  e_rs2);
                3'd7: taken = (e_rs1 >= e_rs2);
                default: taken = 1'b0;
            endcase
        end
        e_exc_any   = m_fault || !legal;
        e_cause     = m_fault ? EXC_FETCH : (!legal ? EXC_ILLEGAL : EXC_NONE);
        e_out_valid = m_held && !flush &&
                      (e_exc_any || !((e_use1 && o1[XLEN]) || (e_use2 && o2[XLEN])));
        e_in_ready  = !flush && (!m_held || (e_out_valid && bus.out_ready));
        e_exc       = e_out_valid && e_exc_any;
        e_redirect  = e_out_valid && bus.out_ready && taken && !e_exc_any;
        e_target    = (op == 7'h67) ? ((e_rs1 + e_imm) & ~32'd1) : (m_pc + e_imm);
    endtask

    always @(posedge clk) begin
        model_eval();
        if (rst || flush) m_held <= 1'b0;
        else if (bus.in_valid && e_in_ready) begin
            m_held  <= 1'b1;
            m_pc    <= bus.in_pc;
            m_instr <= bus.in_instr;
            m_fault <= bus.in_fetch_fault;
        end else if (e_out_valid && bus.out_ready) m_held <= 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            model_eval();
            if (bus.redirect_valid) redir_cnt++;
            check("m_in_ready", bus.in_ready, e_in_ready);
            check("m_out_valid", bus.out_valid, e_out_valid);
            check("m_redirect_valid", bus.redirect_valid, e_redirect);
            check("m_out_exc", bus.out_exc, e_exc);
            if (e_out_valid) begin
                check("m_out_pc", bus.out_pc, m_pc);
                check("m_exc_cause", 64'(bus.out_exc_cause), 64'(e_cause));
                if (!e_exc_any) begin
                    check("m_uop_cls", 64'(bus.out_uop.cls), 64'(e_cls));
                    check("m_uop_funct3", bus.out_uop.funct3, m_instr[14:12]);
                    check("m_uop_funct7", bus.out_uop.funct7, m_instr[31:25]);
                    check("m_uop_rd", bus.out_uop.rd, m_instr[11:7]);
                    check("m_uop_rd_valid", bus.out_uop.rd_valid, e_rdv);
                    check("m_uop_imm", bus.out_uop.imm, e_imm);
                    if (e_use1) check("m_rs1_data", bus.out_rs1_data, e_rs1);
                    if (e_use2) check("m_rs2_data", bus.out_rs2_data, e_rs2);
                end
                if (e_redirect) check("m_redirect_target", bus.redirect_target, e_target);
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] ins, input logic fault);
        logic done;
        done = 1'b0;
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_instr = ins; bus.in_fetch_fault = fault;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_fetch_fault = 1'b0;
        check("send_accepted", done, 1'b1);
    endtask

    logic [31:0] b2b_ins [4] = '{32'h00209463, 32'hFE734EE3, 32'h020000EF, 32'h12345237};
    logic [31:0] b2b_pc  [4] = '{32'h800, 32'h804, 32'h808, 32'h80C};
    logic        b2b_red [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] b2b_tgt [4] = '{32'h0, 32'h800, 32'h828, 32'h0};

    initial begin
        int r0;
        rst = 1'b1; flush = 1'b0; busy1 = 1'b0; busy2 = 1'b0;
        byp_valid = '0; byp_idx = '0; byp_data = '0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.in_fetch_fault = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NREG; i++) regs[i] = 32'h1000 + i;
        regs[0] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_redirect", bus.redirect_valid, 1'b0);
        check("rst_out_exc", bus.out_exc, 1'b0);

        send(32'h100, I_ADDI, 1'b0);
        @(negedge clk);
        check("addi_valid", bus.out_valid, 1'b1);
        check("addi_pc", bus.out_pc, 32'h100);
        check("addi_imm", bus.out_uop.imm, 32'd5);
        check("addi_rs1", bus.out_rs1_data, 32'd0);
        check("addi_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1;

        regs[1] = 32'h11; regs[2] = 32'h22; busy1 = 1'b1;
        send(32'h104, I_ADD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("add_stall_valid", bus.out_valid, 1'b0);
            check("add_stall_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk); #1 busy1 = 1'b0;
        @(negedge clk);
        check("add_valid", bus.out_valid, 1'b1);
        check("add_rs1", bus.out_rs1_data, 32'h11);
        check("add_rs2", bus.out_rs2_data, 32'h22);
        @(posedge clk); #1;

        busy1 = 1'b1; byp_valid = 2'b11;
        byp_idx = {5'd1, 5'd1}; byp_data = {32'hBB, 32'hAA};
        send(32'h108, I_ADD, 1'b0);
        @(negedge clk);
        check("byp_valid", bus.out_valid, 1'b1);
        check("byp_rs1", bus.out_rs1_data, 32'hAA);
        @(posedge clk); #1 busy1 = 1'b0; byp_valid = '0;

        regs[1] = 32'h55; regs[2] = 32'h55;
        bus.out_ready = 1'b0; r0 = redir_cnt;
        send(32'h200, I_BEQ, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("beq_stall_valid", bus.out_valid, 1'b1);
            check("beq_stall_redirect", bus.redirect_valid, 1'b0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("beq_redirect", bus.redirect_valid, 1'b1);
        check("beq_target", bus.redirect_target, 32'h210);
        @(posedge clk); #1;
        @(negedge clk);
        check("beq_after_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check("beq_pulses", redir_cnt - r0, 1);

        regs[5] = 32'h301;
        send(32'h400, I_JALR, 1'b0);
        @(negedge clk);
        check("jalr_redirect", bus.redirect_valid, 1'b1);
        check("jalr_target", bus.redirect_target, 32'h308);
        @(posedge clk); #1;

        busy1 = 1'b1; busy2 = 1'b1;
        send(32'h500, I_ILL, 1'b0);
        @(negedge clk);
        check("ill_valid", bus.out_valid, 1'b1);
        check("ill_exc", bus.out_exc, 1'b1);
        check("ill_cause", 64'(bus.out_exc_cause), 64'(EXC_ILLEGAL));
        check("ill_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1 busy1 = 1'b0; busy2 = 1'b0;

        send(32'h510, I_BADBR, 1'b0);
        @(negedge clk);
        check("badbr_cause", 64'(bus.out_exc_cause), 64'(EXC_ILLEGAL));
        check("badbr_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1;

        send(32'h520, I_BEQ, 1'b1);
        @(negedge clk);
        check("fault_exc", bus.out_exc, 1'b1);
        check("fault_cause", 64'(bus.out_exc_cause), 64'(EXC_FETCH));
        check("fault_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1;

        busy1 = 1'b1; r0 = redir_cnt;
        send(32'h600, I_BEQ, 1'b0);
        @(negedge clk);
        check("flush_pre_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_pc = 32'h700; bus.in_instr = I_ADDI;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1'b0);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1 flush = 1'b0; busy1 = 1'b0;
        @(negedge clk);
        check("post_flush_in_ready", bus.in_ready, 1'b1);
        check("post_flush_out_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_next_valid", bus.out_valid, 1'b1);
        check("post_flush_next_pc", bus.out_pc, 32'h700);
        @(posedge clk); #1;
        check("flush_no_redirect", redir_cnt - r0, 0);

        regs[6] = 32'hFFFFFFFF; regs[7] = 32'h1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = b2b_pc[i]; bus.in_instr = b2b_ins[i];
            @(negedge clk);
            check("b2b_in_ready", bus.in_ready, 1'b1);
            if (i > 0) begin
                check("b2b_valid", bus.out_valid, 1'b1);
                check("b2b_pc", bus.out_pc, b2b_pc[i-1]);
                check("b2b_redirect", bus.redirect_valid, b2b_red[i-1]);
                if (b2b_red[i-1]) check("b2b_target", bus.redirect_target, b2b_tgt[i-1]);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_pc", bus.out_pc, 32'h80C);
        check("b2b_last_redirect", bus.redirect_valid, 1'b0);
        @(posedge clk); #1;

        regs[1] = 32'h55; regs[2] = 32'h55;
        bus.out_ready = 1'b0;
        send(32'h900, I_BEQ, 1'b0);
        @(negedge clk);
        check("rst_stall_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        r0 = redir_cnt;
        rst = 1'b1; flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_pc = 32'hA00; bus.in_instr = I_ADDI;
        @(posedge clk); #1 rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", bus.in_ready, 1'b1);
        check("rst2_out_valid", bus.out_valid, 1'b0);
        check("rst2_redirect", bus.redirect_valid, 1'b0);
        check("rst2_out_exc", bus.out_exc, 1'b0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst2_still_empty", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check("rst2_no_redirect", redir_cnt - r0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_stage_bypass.md
DECODE_STAGE_BYPASS -- requirements
Module: decode_stage_bypass

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter NUM_REGISTERS, 32, architectural registers; RW = $clog2(NUM_REGISTERS).
REQ-003 Parameter BYPASS_PORTS, 2, forwarding channels (>=1).
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  fetch offers instruction; in_ready  out  1  stage accepts.
REQ-007 in_pc  in  XLEN  instruction address; in_instr  in  32  instruction word; in_fetch_fault  in  1  fetch error.
REQ-008 rf_rs1_idx / rf_rs2_idx  out  RW  register-file read indices.
REQ-009 rf_rs1_data / rf_rs2_data  in  XLEN  read data; rf_rs1_busy / rf_rs2_busy  in  1  pending write (scoreboard).
REQ-010 byp_valid  in  BYPASS_PORTS  forward valid; byp_idx  in  BYPASS_PORTS*RW  destination; byp_data  in  BYPASS_PORTS*XLEN  value.
REQ-011 flush  in  1  discard held instruction.
REQ-012 out_valid  out  1; out_ready  in  1; out_pc  out  XLEN; out_uop  out  uop_t (class one-hot, funct3, funct7, rd, rd_valid, imm).
REQ-013 out_rs1_data / out_rs2_data  out  XLEN  resolved operands; out_exc  out  1; out_exc_cause  out  exc_cause_t.
REQ-014 redirect_valid  out  1  taken control transfer; redirect_target  out  XLEN.

Function
REQ-015 One holding register (pc, instr, fetch_fault, held flag); accept when in_valid && in_ready; transfer-out when out_valid && out_ready.
REQ-016 in_ready = !flush && (!held || transfer-out); back-to-back throughput one instruction per cycle.
REQ-017 Latency: instruction accepted at edge N drives out_* combinationally during cycle N+1.
REQ-018 Operand source per rs: index 0 -> zero; else lowest-numbered byp port with byp_valid && byp_idx match; else rf data if !busy; else hazard.
REQ-019 Operand used only if decoder marks rs valid; unused operands never cause hazard.
REQ-020 out_valid = held && !flush && !hazard; exceptions bypass hazard check.
REQ-021 out_exc set for in_fetch_fault (cause FETCH, priority) or invalid opcode/branch funct3 (cause ILLEGAL); redirect_valid 0 for excepting instructions.
REQ-022 Branch compare (eq, ne, lt, ge, ltu, geu) on resolved operands; target pc+imm.
REQ-023 JAL target pc+imm; JALR target (rs1+imm) with bit 0 cleared; all sums modulo 2^XLEN.
REQ-024 redirect_valid asserted only in the transfer-out cycle of a taken branch/jump: exactly one pulse per instruction despite stalls.
REQ-025 flush: held cleared at next edge, no accept that cycle, out_valid and redirect_valid 0 in flush cycle; flush with nothing held is a no-op.
REQ-026 Held inputs stable while stalled; out_* stable while out_valid && !out_ready.

Reset
REQ-027 rst clears held; in_ready 1, out_valid 0, redirect_valid 0, out_exc 0 the cycle after reset; data outputs don't-care.
REQ-028 rst mid-stall discards held instruction without redirect; rst overrides flush and accept.

Structure
REQ-029 decode_pkg holds uop_t, instr_class_t, exc_cause_t, branch funct3 constants, opcode constants.
REQ-030 Existing decoder reused as combinational sub-module; operand selection is a per-rs function of the mux, not a sub-module.

Verification
REQ-031 ADDI x1,x0,5 at pc 0x100, out_ready=1 -> out_valid cycle after accept, imm 5, rs1_data 0, no redirect.
REQ-032 ADD x3,x1,x2, rf_rs1_busy=1 for 3 cycles, no bypass -> out_valid low 3 cycles, in_ready low, then valid with rf data.
REQ-033 Same ADD, rs1 busy, byp0 idx1=0xAA and byp1 idx1=0xBB both valid -> no stall, out_rs1_data 0xAA.
REQ-034 BEQ x1,x2,+16 at 0x200, equal operands, out_ready low 2 cycles -> single redirect pulse, target 0x210, on transfer cycle.
REQ-035 JALR x0,8(x5), x5=0x301 -> redirect_target 0x308; illegal opcode 0x7F -> out_exc ILLEGAL, no redirect.
REQ-036 flush while stalled holding BEQ -> no out_valid, no redirect; next instruction accepted cycle after flush.
